key_debounce: RTL and testbench

- Input-side counterpart to the board's LED output driver: samples the active-low push-button pins.
- Per key: 2-FF synchronisation, then a counter-based debounce.
- Per key outputs: a clean level, a one-cycle press pulse and a one-cycle release pulse.
- Sits between the board key pins and user logic such as LED pattern control or mode selection.

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_filter_ch.sv | 141 ++++++++++++++
 rtl/key_debounce.sv | 38 +++
 tb/tb_key_debounce.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and helpers for the key debounce block.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_FLT = 2'd1,
    PRESSED   = 2'd2,
    REL_FLT   = 2'd3
  } key_st_t;

  function automatic int ms_to_cycles(
    input int clk_freq,
    input int ms
  );
    return (clk_freq / 1000) * ms;
  endfunction

  function automatic int cnt_width(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// One key channel: 2-FF sync, debounce FSM, press/release/long pulses.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_filter_ch
  import key_pkg::*;
#(
  parameter int DB_CNT = 1000000,
  parameter int LP_CNT = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = cnt_width(DB_CNT, LP_CNT);
  localparam logic [CW-1:0] DB_MAX  = CW'(DB_CNT);
  localparam logic [CW-1:0] CNT_TOP = '1;

  logic [1:0]    sync_q;
  logic          key_sync;
  key_st_t       state_q;
  key_st_t       state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lvl_d;
  logic          press_d;
  logic          rel_d;

  assign key_sync = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state   <= lvl_d;
      key_press   <= press_d;
      key_release <= rel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lvl_d   = key_state;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!key_sync) begin
          state_d = PRESS_FLT;
          cnt_d   = CW'(1);
        end
      end
      PRESS_FLT: begin
        if (key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = PRESSED;
          lvl_d   = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_sync) begin
          state_d = REL_FLT;
          cnt_d   = CW'(1);
        end
      end
      REL_FLT: begin
        if (!key_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = IDLE;
          lvl_d   = 1'b0;
          rel_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

`ifdef KEY_LONG_PRESS_EN
  localparam logic [CW-1:0] LP_MAX = CW'(LP_CNT);

  logic [CW-1:0] lp_q;
  logic [CW-1:0] lp_d;
  logic          long_d;
  logic          held;

  assign held = (state_q == PRESSED) || (state_q == REL_FLT);

  // A release being accepted this cycle suppresses a coincident long pulse.
  always_comb begin
    lp_d   = lp_q;
    long_d = 1'b0;
    if (state_q == PRESS_FLT && state_d == PRESSED) begin
      lp_d = '0;
    end else if (held && state_d != IDLE && lp_q != LP_MAX) begin
      lp_d   = lp_q + 1'b1;
      long_d = (lp_d == LP_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lp_q     <= '0;
      key_long <= 1'b0;
    end else begin
      lp_q     <= lp_d;
      key_long <= long_d;
    end
  end
`else
  assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced active-low key inputs with press/release/long pulses.
// Optional long-press pulses enabled by defining KEY_LONG_PRESS_EN.
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int NUM_KEYS    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int DB_CNT = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int LP_CNT = ms_to_cycles(CLK_FREQ, LONG_MS);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_filter_ch #(
      .DB_CNT(DB_CNT),
      .LP_CNT(LP_CNT)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CNT=5, LP_CNT=20.
module tb_key_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_n;
  logic [3:0] key_state;
  logic [3:0] key_press;
  logic [3:0] key_release;
  logic [3:0] key_long;

  int total;
  int bad;

`ifdef KEY_LONG_PRESS_EN
  localparam bit LP_ON = 1'b1;
`else
  localparam bit LP_ON = 1'b0;
`endif

  key_debounce #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(5),
    .LONG_MS    (20),
    .NUM_KEYS   (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // n cycles; pulses expected at cycle `at`, state switches from sb to sa there
  task automatic run(input string tag, input int n, input int at,
                     input logic [3:0] pe, input logic [3:0] re,
                     input logic [3:0] sb, input logic [3:0] sa);
    for (int k = 1; k <= n; k++) begin
      step(1);
      chk({tag, ".press"}, key_press, (k == at) ? pe : 4'b0000);
      chk({tag, ".rel"}, key_release, (k == at) ? re : 4'b0000);
      chk({tag, ".state"}, key_state, (k >= at) ? sa : sb);
      chk({tag, ".excl"}, key_press & key_release, 4'b0000);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    key_n = 4'b1111;
    step(3);
    chk("rst.state", key_state, 4'b0000);
    chk("rst.press", key_press, 4'b0000);
    chk("rst.rel", key_release, 4'b0000);
    chk("rst.long", key_long, 4'b0000);
    rst_n = 1'b1;
    step(3);

    // clean press on key 0
    key_n = 4'b1110;
    run("t1", 10, 8, 4'b0001, 4'b0000, 4'b0000, 4'b0001);

    // bouncing key 1 never accepted
    key_n = 4'b1100;
    run("t2b", 3, 99, 4'b0, 4'b0, 4'b0001, 4'b0001);
    key_n = 4'b1110;
    run("t2b", 1, 99, 4'b0, 4'b0, 4'b0001, 4'b0001);
    key_n = 4'b1100;
    run("t2b", 2, 99, 4'b0, 4'b0, 4'b0001, 4'b0001);
    key_n = 4'b1110;
    run("t2b", 10, 99, 4'b0, 4'b0, 4'b0001, 4'b0001);
    key_n = 4'b1100;
    run("t2", 10, 8, 4'b0010, 4'b0000, 4'b0001, 4'b0011);

    // release of key 0 with a glitch back low
    key_n = 4'b1101;
    run("t3g", 2, 99, 4'b0, 4'b0, 4'b0011, 4'b0011);
    key_n = 4'b1100;
    run("t3g", 2, 99, 4'b0, 4'b0, 4'b0011, 4'b0011);
    key_n = 4'b1101;
    run("t3", 10, 8, 4'b0000, 4'b0001, 4'b0011, 4'b0010);
    key_n = 4'b1111;
    run("t3r", 10, 8, 4'b0000, 4'b0010, 4'b0010, 4'b0000);

    // all keys together
    key_n = 4'b0000;
    run("t4p", 10, 8, 4'b1111, 4'b0000, 4'b0000, 4'b1111);
    key_n = 4'b1111;
    run("t4r", 10, 8, 4'b0000, 4'b1111, 4'b1111, 4'b0000);

    // reset while key 2 is pressed, still held afterwards
    key_n = 4'b1011;
    run("t5p", 10, 8, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    rst_n = 1'b0;
    #1;
    chk("t5.rst.state", key_state, 4'b0000);
    chk("t5.rst.press", key_press, 4'b0000);
    chk("t5.rst.rel", key_release, 4'b0000);
    step(2);
    chk("t5.rst.hold", key_state, 4'b0000);
    rst_n = 1'b1;
    run("t5", 10, 8, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
    key_n = 4'b1111;
    run("t5r", 10, 8, 4'b0000, 4'b0100, 4'b0100, 4'b0000);

    // long press on key 0
    key_n = 4'b1110;
    run("t6p", 8, 8, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
    for (int k = 1; k <= 32; k++) begin
      step(1);
      chk("t6.long", key_long, (LP_ON && k == 20) ? 4'b0001 : 4'b0000);
    end
    key_n = 4'b1111;
    for (int k = 1; k <= 12; k++) begin
      step(1);
      chk("t6.rel.long", key_long, 4'b0000);
    end
    chk("t6.state", key_state, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
